// File: rtl/mc_ctrl_fsm_pkg.sv
// mc_ctrl_fsm_pkg: shared MCCPU control encodings (ALU ops, states, opcodes, functs, mux selects)
package mc_ctrl_fsm_pkg;
  localparam int OP_W = 6;
  localparam int FN_W = 6;
  localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3,
                         ALU_OR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
                         ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SLLV = 4'd10, ALU_SRLV = 4'd11,
                         ALU_LUI = 4'd12;
  typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                              OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0a, OP_ANDI = 6'h0c,
                              OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [FN_W-1:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SLLV = 6'h04, FN_SRLV = 6'h06,
                              FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23,
                              FN_AND = 6'h24, FN_OR = 6'h25, FN_NOR = 6'h27, FN_SLT = 6'h2a,
                              FN_SLTU = 6'h2b;
  localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2;
  localparam logic [1:0] M2R_ALU = 2'd0, M2R_MDR = 2'd1, M2R_PC = 2'd2;
  localparam logic [1:0] SA_PC = 2'd0, SA_RS = 2'd1, SA_SHAMT = 2'd2;
  localparam logic [1:0] SB_RT = 2'd0, SB_4 = 2'd1, SB_IMM = 2'd2, SB_IMM2 = 2'd3;
  localparam logic [1:0] PC_ALU = 2'd0, PC_BR = 2'd1, PC_JMP = 2'd2;
endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: controller <-> datapath/memory signal bundle
interface mc_ctrl_fsm_if;
  import mc_ctrl_fsm_pkg::*;
  logic [OP_W-1:0] Op;
  logic [FN_W-1:0] Funct;
  logic Zero, mem_rdy;
  logic mem_req, IorD, MemWrite, IRWrite, PCWrite, RegWrite, illegal;
  logic [1:0] PCSource, RegDst, MemtoReg, ALUSrcA, ALUSrcB;
  logic [3:0] ALUOp;
  logic [2:0] state;
  modport master (input Op, Funct, Zero, mem_rdy,
                  output mem_req, IorD, MemWrite, IRWrite, PCWrite, PCSource, RegWrite,
                         RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, illegal, state);
  modport slave (output Op, Funct, Zero, mem_rdy,
                 input mem_req, IorD, MemWrite, IRWrite, PCWrite, PCSource, RegWrite,
                       RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, illegal, state);
endinterface

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: combinational (state, Op, Funct) -> ALUOp / illegal map
module mc_alu_dec
  import mc_ctrl_fsm_pkg::*;
(
  input  state_t          state,
  input  logic [OP_W-1:0] op,
  input  logic [FN_W-1:0] fn,
  output logic [3:0]      alu_op,
  output logic            illegal
);
  logic [3:0] f_op, i_op;
  logic f_ok, i_ok;
  always_comb begin
    f_op = ALU_NOP;
    f_ok = 1'b1;
    case (fn)
      FN_ADD, FN_ADDU: f_op = ALU_ADD;
      FN_SUB, FN_SUBU: f_op = ALU_SUB;
      FN_AND:          f_op = ALU_AND;
      FN_OR:           f_op = ALU_OR;
      FN_NOR:          f_op = ALU_NOR;
      FN_SLT:          f_op = ALU_SLT;
      FN_SLTU:         f_op = ALU_SLTU;
      FN_SLL:          f_op = ALU_SLL;
      FN_SRL:          f_op = ALU_SRL;
      FN_SLLV:         f_op = ALU_SLLV;
      FN_SRLV:         f_op = ALU_SRLV;
      default:         f_ok = 1'b0;
    endcase
    i_op = ALU_NOP;
    i_ok = 1'b1;
    case (op)
      OP_RTYPE, OP_J, OP_JAL:   i_op = ALU_NOP;
      OP_BEQ, OP_BNE:           i_op = ALU_SUB;
      OP_ADDI, OP_LW, OP_SW:    i_op = ALU_ADD;
      OP_ANDI:                  i_op = ALU_AND;
      OP_ORI:                   i_op = ALU_OR;
      OP_SLTI:                  i_op = ALU_SLT;
      OP_LUI:                   i_op = ALU_LUI;
      default:                  i_ok = 1'b0;
    endcase
    // IF increments PC, ID precomputes the branch target; both are plain adds
    alu_op = (state == S_IF || state == S_ID) ? ALU_ADD :
             state != S_EXE ? ALU_NOP : op == OP_RTYPE ? f_op : i_op;
    illegal = (state == S_ID && !i_ok) || (state == S_EXE && op == OP_RTYPE && !f_ok);
  end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MCCPU control sequencer (IF/ID/EXE/MEM/WB)
// Optional MC_PERF_CNT_EN adds cyc_cnt/inst_cnt performance counters.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
(
  input logic clk,
  input logic rst,
  mc_ctrl_fsm_if.master bus
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] inst_cnt
`endif
);
  state_t st, nxt;
  logic [3:0] alu_op;
  logic ill;
  logic is_r, is_j, is_jal, is_br, is_lw, is_sw;
  assign is_r   = bus.Op == OP_RTYPE;
  assign is_j   = bus.Op == OP_J;
  assign is_jal = bus.Op == OP_JAL;
  assign is_br  = bus.Op == OP_BEQ || bus.Op == OP_BNE;
  assign is_lw  = bus.Op == OP_LW;
  assign is_sw  = bus.Op == OP_SW;
  mc_alu_dec u_dec (.state(st), .op(bus.Op), .fn(bus.Funct), .alu_op(alu_op), .illegal(ill));
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= S_IF;
    else     st <= nxt;
  // Everything is forced quiet while rst is high, even though st is already S_IF
  always_comb begin
    nxt          = st;
    bus.state    = st;
    bus.ALUOp    = rst ? ALU_NOP : alu_op;
    bus.illegal  = !rst && ill;
    bus.mem_req  = 1'b0;
    bus.IorD     = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.RegWrite = 1'b0;
    bus.PCSource = PC_ALU;
    bus.RegDst   = RD_RT;
    bus.MemtoReg = M2R_ALU;
    bus.ALUSrcA  = SA_PC;
    bus.ALUSrcB  = SB_RT;
    if (!rst)
      case (st)
        S_IF: begin
          bus.mem_req = 1'b1;
          bus.ALUSrcB = SB_4;
          bus.IRWrite = bus.mem_rdy;
          bus.PCWrite = bus.mem_rdy;
          nxt = bus.mem_rdy ? S_ID : S_IF;
        end
        S_ID: begin
          bus.ALUSrcB  = SB_IMM2;
          bus.PCWrite  = is_j || is_jal;
          bus.PCSource = (is_j || is_jal) ? PC_JMP : PC_ALU;
          bus.RegWrite = is_jal;
          bus.RegDst   = is_jal ? RD_RA : RD_RT;
          bus.MemtoReg = is_jal ? M2R_PC : M2R_ALU;
          nxt = (ill || is_j || is_jal) ? S_IF : S_EXE;
        end
        S_EXE: begin
          bus.ALUSrcA  = (is_r && (bus.Funct == FN_SLL || bus.Funct == FN_SRL)) ? SA_SHAMT : SA_RS;
          bus.ALUSrcB  = (is_r || is_br) ? SB_RT : SB_IMM;
          bus.PCSource = is_br ? PC_BR : PC_ALU;
          bus.PCWrite  = is_br && (bus.Op == OP_BEQ ? bus.Zero : !bus.Zero);
          nxt = (ill || is_br) ? S_IF : (is_lw || is_sw) ? S_MEM : S_WB;
        end
        S_MEM: begin
          bus.mem_req  = 1'b1;
          bus.IorD     = 1'b1;
          bus.MemWrite = is_sw && bus.mem_rdy;
          nxt = !bus.mem_rdy ? S_MEM : is_sw ? S_IF : S_WB;
        end
        S_WB: begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = is_r ? RD_RD : RD_RT;
          bus.MemtoReg = is_lw ? M2R_MDR : M2R_ALU;
          nxt = S_IF;
        end
        default: nxt = S_IF;
      endcase
  end
`ifdef MC_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (nxt == S_IF && st != S_IF && !ill) inst_cnt <= inst_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: randomized scoreboard bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;
  import mc_ctrl_fsm_pkg::*;
  typedef struct packed {
    logic [2:0] st;
    logic mem_req, iord, memwrite, irwrite, pcwrite;
    logic [1:0] pcsrc;
    logic regwrite;
    logic [1:0] regdst, memtoreg, srca, srcb;
    logic [3:0] aluop;
    logic illegal;
  } rec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0, errs = 0, cyc_m = 0, inst_m = 0;
  rec_t exp_q[$];
  logic [5:0] ops [13];
  logic [5:0] fns [13];
  mc_ctrl_fsm_if bus ();
`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_cnt, inst_cnt, c0, i0;
  mc_ctrl_fsm dut (.clk(clk), .rst(rst), .bus(bus), .cyc_cnt(cyc_cnt), .inst_cnt(inst_cnt));
`else
  mc_ctrl_fsm dut (.clk(clk), .rst(rst), .bus(bus));
`endif
  always #5 clk = ~clk;

  always @(negedge clk)
    if (exp_q.size() > 0) begin
      rec_t g, e;
      g = {bus.state, bus.mem_req, bus.IorD, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.PCSource,
           bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.illegal};
      e = exp_q.pop_front();
      vecs++;
      if (g !== e) begin
        errs++;
        $display("FAIL ctrl_outputs t=%0t got=%h exp=%h (exp state %0d)", $time, g, e, e.st);
      end
    end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // {legal, ALU op} for each R-type funct
  function automatic logic [4:0] fn_ref(input logic [5:0] f);
    case (f)
      FN_ADD, FN_ADDU: return {1'b1, ALU_ADD};
      FN_SUB, FN_SUBU: return {1'b1, ALU_SUB};
      FN_AND:  return {1'b1, ALU_AND};
      FN_OR:   return {1'b1, ALU_OR};
      FN_NOR:  return {1'b1, ALU_NOR};
      FN_SLT:  return {1'b1, ALU_SLT};
      FN_SLTU: return {1'b1, ALU_SLTU};
      FN_SLL:  return {1'b1, ALU_SLL};
      FN_SRL:  return {1'b1, ALU_SRL};
      FN_SLLV: return {1'b1, ALU_SLLV};
      FN_SRLV: return {1'b1, ALU_SRLV};
      default: return {1'b0, ALU_NOP};
    endcase
  endfunction

  // {legal, ALU op used in EXE} for each opcode
  function automatic logic [4:0] op_ref(input logic [5:0] o);
    case (o)
      OP_RTYPE, OP_J, OP_JAL: return {1'b1, ALU_NOP};
      OP_BEQ, OP_BNE:         return {1'b1, ALU_SUB};
      OP_ADDI, OP_LW, OP_SW:  return {1'b1, ALU_ADD};
      OP_ANDI: return {1'b1, ALU_AND};
      OP_ORI:  return {1'b1, ALU_OR};
      OP_SLTI: return {1'b1, ALU_SLT};
      OP_LUI:  return {1'b1, ALU_LUI};
      default: return {1'b0, ALU_NOP};
    endcase
  endfunction

  task automatic cyc(input rec_t e, input logic mr, input logic z);
    bus.mem_rdy = mr;
    bus.Zero = z;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (!rst) cyc_m++;
  endtask

  // One instruction as a sequence of phases; abort resets the DUT in the final MEM cycle
  task automatic run_inst(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input int s_if, input int s_mem, input bit abort);
    rec_t e;
    logic [4:0] o, f;
    o = op_ref(op);
    f = fn_ref(fn);
    bus.Op = 6'($urandom);
    bus.Funct = 6'($urandom);
    e = '0; e.st = S_IF; e.mem_req = 1'b1; e.srcb = SB_4; e.aluop = ALU_ADD;
    repeat (s_if) cyc(e, 1'b0, rb());
    e.irwrite = 1'b1; e.pcwrite = 1'b1;
    cyc(e, 1'b1, rb());
    bus.Op = op;
    bus.Funct = fn;
    e = '0; e.st = S_ID; e.srcb = SB_IMM2; e.aluop = ALU_ADD;
    if (!o[4]) begin
      e.illegal = 1'b1;
      cyc(e, rb(), rb());
      return;
    end
    if (op == OP_J || op == OP_JAL) begin
      e.pcwrite = 1'b1; e.pcsrc = PC_JMP;
      if (op == OP_JAL) begin e.regwrite = 1'b1; e.regdst = RD_RA; e.memtoreg = M2R_PC; end
      cyc(e, rb(), rb());
      inst_m++;
      return;
    end
    cyc(e, rb(), rb());
    e = '0; e.st = S_EXE; e.srca = SA_RS;
    if (op == OP_RTYPE) begin
      if (fn == FN_SLL || fn == FN_SRL) e.srca = SA_SHAMT;
      e.aluop = f[3:0];
      e.illegal = !f[4];
      cyc(e, rb(), rb());
      if (!f[4]) return;
    end else if (op == OP_BEQ || op == OP_BNE) begin
      e.aluop = ALU_SUB; e.pcsrc = PC_BR; e.pcwrite = (op == OP_BEQ) ? z : !z;
      cyc(e, rb(), z);
      inst_m++;
      return;
    end else begin
      e.srcb = SB_IMM; e.aluop = o[3:0];
      cyc(e, rb(), rb());
    end
    if (op == OP_LW || op == OP_SW) begin
      e = '0; e.st = S_MEM; e.mem_req = 1'b1; e.iord = 1'b1;
      repeat (s_mem) cyc(e, 1'b0, rb());
      if (abort) begin
        bus.mem_rdy = 1'b1;
        rst = 1'b1;
        exp_q.push_back(rec_t'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc_m = 0;
        inst_m = 0;
        return;
      end
      e.memwrite = (op == OP_SW);
      cyc(e, 1'b1, rb());
      if (op == OP_SW) begin inst_m++; return; end
    end
    e = '0; e.st = S_WB; e.regwrite = 1'b1;
    e.regdst = (op == OP_RTYPE) ? RD_RD : RD_RT;
    e.memtoreg = (op == OP_LW) ? M2R_MDR : M2R_ALU;
    cyc(e, rb(), rb());
    inst_m++;
  endtask

  initial begin
    ops = '{OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
            OP_LUI, OP_LW, OP_SW, 6'h3f};
    fns = '{FN_SLL, FN_SRL, FN_SLLV, FN_SRLV, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND,
            FN_OR, FN_NOR, FN_SLT, FN_SLTU};
    bus.Op = '0; bus.Funct = '0; bus.Zero = 1'b0; bus.mem_rdy = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) cyc(rec_t'(0), 1'b1, 1'b0);
    rst = 1'b0;
    run_inst(OP_RTYPE, FN_ADD, 1'b0, 0, 0, 1'b0);
    run_inst(OP_LW, 6'h11, 1'b0, 0, 2, 1'b0);
    run_inst(OP_BEQ, 6'h00, 1'b1, 0, 0, 1'b0);
    run_inst(OP_BEQ, 6'h00, 1'b0, 0, 0, 1'b0);
    run_inst(OP_BNE, 6'h00, 1'b1, 0, 0, 1'b0);
    run_inst(OP_BNE, 6'h00, 1'b0, 0, 0, 1'b0);
    run_inst(OP_JAL, 6'h00, 1'b0, 0, 0, 1'b0);
    run_inst(OP_J, 6'h00, 1'b0, 1, 0, 1'b0);
`ifdef MC_PERF_CNT_EN
    c0 = cyc_cnt;
    i0 = inst_cnt;
`endif
    run_inst(6'h3f, FN_ADD, 1'b0, 0, 0, 1'b0);
`ifdef MC_PERF_CNT_EN
    vecs++;
    if (cyc_cnt - c0 !== 32'd2 || inst_cnt !== i0) begin
      errs++;
      $display("FAIL perf_illegal cyc_delta=%0d exp=2 inst_cnt=%0d exp=%0d", cyc_cnt - c0, inst_cnt, i0);
    end
`endif
    run_inst(OP_RTYPE, 6'h3f, 1'b0, 0, 0, 1'b0);
    run_inst(OP_SW, 6'h00, 1'b0, 0, 1, 1'b1);
    run_inst(OP_RTYPE, FN_SLL, 1'b0, 1, 0, 1'b0);
    run_inst(OP_SW, 6'h00, 1'b0, 2, 2, 1'b0);
    for (int i = 0; i < 250; i++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 12)];
      fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 12)];
      run_inst(op, fn, rb(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0, 1'b0);
    end
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    vecs++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
`ifdef MC_PERF_CNT_EN
    vecs++;
    if (cyc_cnt !== 32'(cyc_m)) begin
      errs++;
      $display("FAIL cyc_cnt got=%0d exp=%0d", cyc_cnt, cyc_m);
    end
    vecs++;
    if (inst_cnt !== 32'(inst_m)) begin
      errs++;
      $display("FAIL inst_cnt got=%0d exp=%0d", inst_cnt, inst_m);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
